// File: rtl/mm_iddmm_res_wb.sv
// mm_iddmm_res_wb: result write-back initiator for the IDDMM compare-and-subtract
// stage. Requests a task, collects N result words (LS word first) into the
// result RAM through a registered write port, and reports done with status.
// Optional build macro: MM_IDDMM_RES_CHK_EN adds a running XOR checksum output.
module mm_iddmm_res_wb #(
  parameter int unsigned K = 128,
  parameter int unsigned N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 task_req,
  input  logic                 task_end,
  input  logic [K-1:0]         res,
  input  logic                 res_val,
  output logic                 wr_en,
  output logic [$clog2(N)-1:0] wr_addr,
  output logic [K-1:0]         wr_data,
  output logic                 err_ovf,
  output logic                 err_short,
  output logic                 res_zero
`ifdef MM_IDDMM_RES_CHK_EN
  ,
  output logic [K-1:0]         chk
`endif
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] NCNT = CW'(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic           zero_q, zero_d;
  logic           ovf_q, ovf_d;
  logic           short_q, short_d;
  logic           rzero_q, rzero_d;
  logic           wr_en_q, wr_en_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [K-1:0]   wr_data_q, wr_data_d;
  logic [K-1:0]   chk_q, chk_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      zero_q    <= 1'b1;
      ovf_q     <= 1'b0;
      short_q   <= 1'b0;
      rzero_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      chk_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      short_q   <= short_d;
      rzero_q   <= rzero_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      chk_q     <= chk_d;
    end
  end

  // Next-state, word capture and status flag logic.
  // The word accepted in a cycle updates count_d first, so the short check on
  // task_end and the res_zero capture see a simultaneous final word.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    short_d   = short_q;
    rzero_d   = rzero_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    chk_d     = chk_q;
    busy      = 1'b0;
    done      = 1'b0;
    task_req  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          count_d = '0;
          zero_d  = 1'b1;
          ovf_d   = 1'b0;
          short_d = 1'b0;
          rzero_d = 1'b0;
          chk_d   = '0;
        end
      end

      S_REQ, S_DRAIN: begin
        busy     = 1'b1;
        task_req = (state_q == S_REQ);
        if (res_val) begin
          if (count_q < NCNT) begin
            wr_en_d   = 1'b1;
            wr_addr_d = count_q[AW-1:0];
            wr_data_d = res;
            count_d   = count_q + CW'(1);
            zero_d    = zero_q & (res == '0);
            chk_d     = chk_q ^ res;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (state_q == S_REQ) begin
          if (task_end) begin
            state_d = S_DRAIN;
            if (count_d < NCNT) begin
              short_d = 1'b1;
            end
          end
        end else begin
          state_d = S_DONE;
          rzero_d = zero_d & (count_d == NCNT);
        end
      end

      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign err_ovf   = ovf_q;
  assign err_short = short_q;
  assign res_zero  = rzero_q;

`ifdef MM_IDDMM_RES_CHK_EN
  assign chk = chk_q;
`else
  logic unused_chk;
  assign unused_chk = ^chk_q;
`endif

endmodule

// File: tb/tb_mm_iddmm_res_wb.sv
// Bench for mm_iddmm_res_wb: scenario table plus a write scoreboard that
// checks every RAM write (address, data, cycle) against the driven words.
module tb_mm_iddmm_res_wb;

  localparam int K = 128;
  localparam int N = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 task_req;
  logic                 task_end;
  logic [K-1:0]         res;
  logic                 res_val;
  logic                 wr_en;
  logic [$clog2(N)-1:0] wr_addr;
  logic [K-1:0]         wr_data;
  logic                 err_ovf;
  logic                 err_short;
  logic                 res_zero;
`ifdef MM_IDDMM_RES_CHK_EN
  logic [K-1:0]         chk;
`endif

  mm_iddmm_res_wb #(.K(K), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .task_req (task_req),
    .task_end (task_end),
    .res      (res),
    .res_val  (res_val),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .err_ovf  (err_ovf),
    .err_short(err_short),
    .res_zero (res_zero)
`ifdef MM_IDDMM_RES_CHK_EN
    ,
    .chk      (chk)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    nw;
    bit    zero;
    bit    simul;
    bit    e_ovf;
    bit    e_short;
    bit    e_zero;
  } case_t;

  typedef struct {
    int           addr;
    logic [K-1:0] data;
    int           cyc;
  } wr_item_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  wr_item_t     sb[$];
  logic [K-1:0] mem [N];
  bit           written [N];
  case_t        cases [5];

  task automatic check(input string nm, input logic [K-1:0] act, input logic [K-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every write must match the oldest expected word.
  always @(negedge clk) begin
    wr_item_t e;
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        check("wr_addr", K'(wr_addr), K'(e.addr));
        check("wr_data", wr_data, e.data);
        check("wr_latency", K'(cyc), K'(e.cyc));
      end
      mem[wr_addr]     = wr_data;
      written[wr_addr] = 1'b1;
    end
  end

  function automatic logic [K-1:0] word_of(input int i, input bit zero);
    if (zero) return '0;
    if (i == N) return K'(32'hDEAD);
    return K'(i + 1);
  endfunction

  task automatic run_case(input case_t c);
    logic [K-1:0] exp_chk;
    logic [K-1:0] d;
    bit           got;
    int           nw_eff;
    exp_chk = '0;
    for (int a = 0; a < N; a++) begin
      written[a] = 1'b0;
      mem[a]     = '0;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({c.name, ".busy_req"}, K'(busy), K'(1));
    check({c.name, ".task_req_up"}, K'(task_req), K'(1));
    for (int i = 0; i < c.nw; i++) begin
      d        = word_of(i, c.zero);
      res_val  = 1'b1;
      res      = d;
      start    = (i == 5);
      task_end = c.simul && (i == c.nw - 1);
      if (i < N) begin
        sb.push_back('{addr: i, data: d, cyc: cyc + 1});
        exp_chk ^= d;
      end
      @(posedge clk); #1;
    end
    res_val = 1'b0;
    start   = 1'b0;
    if (!c.simul) begin
      task_end = 1'b1;
      @(posedge clk); #1;
    end
    task_end = 1'b0;
    check({c.name, ".task_req_fall"}, K'(task_req), K'(0));
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.done_timeout: got no done expected done within 10 cycles", c.name);
    end else begin
      check({c.name, ".err_ovf"}, K'(err_ovf), K'(c.e_ovf));
      check({c.name, ".err_short"}, K'(err_short), K'(c.e_short));
      check({c.name, ".res_zero"}, K'(res_zero), K'(c.e_zero));
      check({c.name, ".busy_done"}, K'(busy), K'(1));
`ifdef MM_IDDMM_RES_CHK_EN
      check({c.name, ".chk"}, chk, exp_chk);
`endif
      @(posedge clk); #1;
      check({c.name, ".done_pulse"}, K'(done), K'(0));
      check({c.name, ".busy_off"}, K'(busy), K'(0));
      check({c.name, ".res_zero_hold"}, K'(res_zero), K'(c.e_zero));
    end
    @(posedge clk); #1;
    check({c.name, ".sb_empty"}, K'(sb.size()), K'(0));
    nw_eff = (c.nw < N) ? c.nw : N;
    for (int a = 0; a < N; a++) begin
      check({c.name, ".written"}, K'(written[a]), K'(a < nw_eff));
      if (a < nw_eff) check({c.name, ".mem"}, mem[a], word_of(a, c.zero));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cases[0] = '{name: "nominal", nw: 32, zero: 0, simul: 0, e_ovf: 0, e_short: 0, e_zero: 0};
    cases[1] = '{name: "zero",    nw: 32, zero: 1, simul: 0, e_ovf: 0, e_short: 0, e_zero: 1};
    cases[2] = '{name: "short",   nw: 31, zero: 0, simul: 0, e_ovf: 0, e_short: 1, e_zero: 0};
    cases[3] = '{name: "ovf",     nw: 33, zero: 0, simul: 0, e_ovf: 1, e_short: 0, e_zero: 0};
    cases[4] = '{name: "simul",   nw: 32, zero: 0, simul: 1, e_ovf: 0, e_short: 0, e_zero: 0};

    rst = 1'b1; start = 1'b0; task_end = 1'b0; res = '0; res_val = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", K'(busy), K'(0));
    check("rst.done", K'(done), K'(0));
    check("rst.task_req", K'(task_req), K'(0));
    check("rst.wr_en", K'(wr_en), K'(0));
    check("rst.wr_addr", K'(wr_addr), K'(0));
    check("rst.wr_data", wr_data, '0);
    check("rst.err_ovf", K'(err_ovf), K'(0));
    check("rst.err_short", K'(err_short), K'(0));
    check("rst.res_zero", K'(res_zero), K'(0));
`ifdef MM_IDDMM_RES_CHK_EN
    check("rst.chk", chk, '0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++) run_case(cases[t]);

    // Reset in the middle of a collection, then stray res_val in IDLE.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      res_val = 1'b1;
      res     = word_of(i, 1'b0);
      sb.push_back('{addr: i, data: res, cyc: cyc + 1});
      @(posedge clk); #1;
    end
    res_val = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst.task_req", K'(task_req), K'(0));
    check("midrst.busy", K'(busy), K'(0));
    check("midrst.wr_en", K'(wr_en), K'(0));
    check("midrst.err_ovf", K'(err_ovf), K'(0));
    check("midrst.err_short", K'(err_short), K'(0));
    for (int i = 0; i < 3; i++) begin
      res_val = 1'b1;
      res     = K'(32'hBAD0 + i);
      @(posedge clk); #1;
    end
    res_val = 1'b0;
    @(posedge clk); #1;
    check("idle.wr_en", K'(wr_en), K'(0));
    check("idle.busy", K'(busy), K'(0));
    check("idle.sb_empty", K'(sb.size()), K'(0));
    run_case('{name: "after_rst", nw: 32, zero: 0, simul: 0, e_ovf: 0, e_short: 0, e_zero: 0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
